// File: rtl/cic_interp_sequencer.sv
// rtl/cic_interp_sequencer.sv - tick, handshake and strobe sequencer for the CIC interpolation chain
// The first enabled cycle only loads the ratio, so the first tick lands div_cfg+1 cycles later.
module cic_interp_sequencer #(
  parameter int DATA_W  = 32,
  parameter int RATIO_W = 16,
  parameter int DIV_W   = 8,
  parameter int UCNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [RATIO_W-1:0] ratio_cfg,
  input  logic [DIV_W-1:0]   div_cfg,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               comb_ena,
  output logic [DATA_W-1:0]  comb_in,
  output logic               integ_ena,
  output logic               zs_sel,
  output logic               out_ena,
  output logic               underrun,
  output logic [UCNT_W-1:0]  underrun_cnt,
  output logic [RATIO_W-1:0] phase
);

  localparam logic [RATIO_W-1:0] R_ONE = RATIO_W'(1);
  localparam logic [DIV_W-1:0]   D_ONE = DIV_W'(1);
  localparam logic [UCNT_W-1:0]  U_ONE = UCNT_W'(1);

  logic               run_q;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [RATIO_W-1:0] phase_q, phase_d;
  logic [RATIO_W-1:0] ratio_q, ratio_d;
  logic               buf_full_q, buf_full_d;
  logic [DATA_W-1:0]  buf_q, buf_d;
  logic [DATA_W-1:0]  comb_in_q, comb_in_d;
  logic [UCNT_W-1:0]  ucnt_q, ucnt_d;
  logic               comb_ena_q, underrun_q;
  logic               tick1_q, slot1_q;
  logic               integ_ena_q, zs_sel_q, out_ena_q;

  logic               first, running, tick, slot, wrap, consume, accept;
  logic [RATIO_W-1:0] ratio_cfg_m;

  always_comb begin
    first       = en & ~run_q;
    running     = en & run_q;
    tick        = running & (div_cnt_q >= div_cfg);
    slot        = tick & (phase_q == '0);
    wrap        = phase_q >= (ratio_q - R_ONE);
    ratio_cfg_m = (ratio_cfg == '0) ? R_ONE : ratio_cfg;
    consume     = slot & buf_full_q;
    in_ready    = en & ~rst & (~buf_full_q | consume);
    accept      = in_valid & in_ready;
  end

  always_comb begin
    div_cnt_d = '0;
    if (running && !tick)
      div_cnt_d = div_cnt_q + D_ONE;

    phase_d = phase_q;
    ratio_d = ratio_q;
    if (!en) begin
      phase_d = '0;
    end else if (first) begin
      phase_d = '0;
      ratio_d = ratio_cfg_m;
    end else if (tick) begin
      // The ratio only reloads at the frame boundary so a frame is never cut short.
      if (wrap) begin
        phase_d = '0;
        ratio_d = ratio_cfg_m;
      end else begin
        phase_d = phase_q + R_ONE;
      end
    end

    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    if (accept) begin
      buf_full_d = 1'b1;
      buf_d      = in_data;
    end else if (consume) begin
      buf_full_d = 1'b0;
    end

    comb_in_d = comb_in_q;
    ucnt_d    = ucnt_q;
    if (slot) begin
      comb_in_d = buf_full_q ? buf_q : '0;
      if (!buf_full_q && (ucnt_q != '1))
        ucnt_d = ucnt_q + U_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q       <= 1'b0;
      div_cnt_q   <= '0;
      phase_q     <= '0;
      ratio_q     <= '0;
      buf_full_q  <= 1'b0;
      buf_q       <= '0;
      comb_in_q   <= '0;
      ucnt_q      <= '0;
      comb_ena_q  <= 1'b0;
      underrun_q  <= 1'b0;
      tick1_q     <= 1'b0;
      slot1_q     <= 1'b0;
      integ_ena_q <= 1'b0;
      zs_sel_q    <= 1'b0;
      out_ena_q   <= 1'b0;
    end else begin
      run_q       <= en;
      div_cnt_q   <= div_cnt_d;
      phase_q     <= phase_d;
      ratio_q     <= ratio_d;
      buf_full_q  <= buf_full_d;
      buf_q       <= buf_d;
      comb_in_q   <= comb_in_d;
      ucnt_q      <= ucnt_d;
      comb_ena_q  <= slot;
      underrun_q  <= slot & ~buf_full_q;
      tick1_q     <= tick;
      slot1_q     <= slot;
      integ_ena_q <= tick1_q;
      zs_sel_q    <= slot1_q;
      out_ena_q   <= integ_ena_q;
    end
  end

  assign comb_ena     = comb_ena_q;
  assign comb_in      = comb_in_q;
  assign integ_ena    = integ_ena_q;
  assign zs_sel       = zs_sel_q;
  assign out_ena      = out_ena_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = ucnt_q;
  assign phase        = phase_q;

endmodule

// File: doc/cic_interp_sequencer.md
Name: cic_interp_sequencer

Overview:
- Timing and handshake controller for the CIC interpolation chain in the sigma-delta DAC path.
- Derives the output-rate tick from clk, accepts input samples through a valid/ready handshake, and strobes the comb stages once per interpolation frame.
- Strobes the integrator stages and the modulator every output tick, with the zero-stuff select aligned to the comb stage latency.
- Detects and counts input underruns.

Parameters:
- DATA_W, 32: sample width, matches comb/integrator BITWIDTH.
- RATIO_W, 16: width of the interpolation ratio.
- DIV_W, 8: width of the clk-to-output-rate divider.
- UCNT_W, 16: width of the underrun counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable.
- ratio_cfg  in  RATIO_W  interpolation ratio R; 0 is treated as 1.
- div_cfg  in  DIV_W  output tick every div_cfg+1 clk cycles.
- in_valid  in  1  upstream sample valid.
- in_data  in  DATA_W  upstream sample.
- in_ready  out  1  sequencer can accept a sample.
- comb_ena  out  1  one-cycle enable to all comb stages.
- comb_in  out  DATA_W  sample presented to the first comb stage.
- integ_ena  out  1  one-cycle enable to all integrator stages.
- zs_sel  out  1  1 = pass comb output to the integrators, 0 = insert zero.
- out_ena  out  1  one-cycle enable to the sigma-delta modulator.
- underrun  out  1  one-cycle pulse when a frame starts with no sample available.
- underrun_cnt  out  UCNT_W  saturating underrun count.
- phase  out  RATIO_W  current position within the frame, 0..R-1.

Behaviour:
- Reset (rst=1 at a clk edge):
  - div_cnt, phase, ratio_q and all strobes go to 0.
  - comb_in=0, underrun_cnt=0.
  - Sample buffer is emptied.
  - Reset mid-frame aborts the frame; no further strobes are issued from the aborted frame.
- Enable:
  - en=0: div_cnt and phase held at 0, no tick, no strobes, in_ready=0.
  - en=0 does not discard a buffered sample.
  - On the first en=1 cycle after en=0 or reset: ratio_q <= max(ratio_cfg,1), and the first tick occurs after div_cfg+1 cycles.
- Divider:
  - div_cnt counts 0..div_cfg.
  - tick is asserted in the cycle div_cnt==div_cfg, then div_cnt wraps to 0.
  - div_cfg=0 gives a tick every cycle.
  - div_cfg is read live.
- Phase:
  - Advances on each tick, wrapping after ratio_q-1.
  - A tick with phase==0 is the frame slot.
  - ratio_q reloads from ratio_cfg only on the tick where phase wraps to 0, so ratio changes never truncate a frame.
- Buffer (one entry):
  - in_ready = en & (!buf_full | consume), where consume = tick & phase==0 & buf_full.
  - Accept occurs when in_valid & in_ready; accept and consume in the same cycle are legal, and buf_full stays 1 holding the new sample.
  - Samples offered while full are not accepted; upstream holds them.
- Pipeline, relative to the slot tick at cycle t:
  - t+1: comb_ena=1; comb_in = buffered sample, or 0 on underrun. comb_in holds until the next frame.
  - t+1: underrun=1 if the buffer was empty at t; underrun_cnt increments, saturating at all-ones.
  - Every tick at t gives integ_ena=1 at t+2, with zs_sel=1 only if that tick was a frame slot, else zs_sel=0.
  - Every tick at t gives out_ena=1 at t+3.
  - All strobes are single-cycle and registered.
  - Strobes already in the pipeline complete after en falls. They are cleared by rst.
- Boundary cases:
  - R=1: every tick is a frame slot, so comb_ena and integ_ena fire every tick with zs_sel=1.
  - div_cfg=0 with R=1: the buffer is consumed every cycle; full throughput requires in_valid to be continuous.
  - Back-to-back ticks keep strobes separate: each pipeline stage is an independent flop.

Test Plan:
- Reset then en=1, div_cfg=3, R=4, in_valid=1 with data 0x10,0x20,…:
  - tick every 4 clk; comb_ena every 16 clk with comb_in=0x10, then 0x20.
  - integ_ena every 4 clk with zs_sel pattern 1,0,0,0.
  - out_ena 1 cycle after each integ_ena.
- div_cfg=0, R=1, continuous valid: in_ready stays 1; comb_ena, integ_ena and out_ena are each high every cycle after the pipeline fills; no underrun.
- R=8, in_valid low for 2 frames: underrun pulses twice; comb_in=0 on those frames; underrun_cnt=2; the phase sequence is unaffected.
- Change ratio_cfg from 4 to 2 at phase=1: the current frame completes 4 ticks, and the following frames are 2 ticks long.
- en dropped at phase=2 with a full buffer:
  - in_ready=0, phase=0, in-flight strobes drain.
  - On re-enable, the buffered sample is emitted at the first frame slot.
- rst asserted mid-frame with a full buffer: all outputs are 0 the next cycle; underrun_cnt=0; the buffer is empty (the first post-reset slot underruns if no new sample arrives).
